// File: rtl/voter_pkg.sv
// Shared types and constants for the 4-voter decision path: session FSM states,
// one-hot decision codes and the one-hot legality check used when sampling the voter.
package voter_pkg;

    localparam int N_VOTERS = 4;
    localparam int ID_W     = $clog2(N_VOTERS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [2:0] DEC_YES  = 3'b100;
    localparam logic [2:0] DEC_TIE  = 3'b010;
    localparam logic [2:0] DEC_NO   = 3'b001;
    localparam logic [2:0] DEC_NONE = 3'b000;

    // Only the three defined codes are legal; 000 and any multi-hot value are not.
    function automatic logic is_decision(input logic [2:0] v);
        return (v == DEC_YES) || (v == DEC_TIE) || (v == DEC_NO);
    endfunction

endpackage

// File: rtl/ballot_window_timer.sv
// Collect-window timer: counts enabled cycles from a clear and flags the last
// cycle of the window; it parks on that value rather than wrapping.
module ballot_window_timer #(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    assign expire = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ballot_collector.sv
// Session controller in front of the 4-voter decision unit: gathers one vote per
// voter within a timed window, lets the voter settle, then latches its decision.
module ballot_collector
    import voter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                vote_valid,
    input  logic [ID_W-1:0]     voter_id,
    input  logic                vote_val,
    input  logic [2:0]          result,
    output logic [N_VOTERS-1:0] ballot,
    output logic [N_VOTERS-1:0] voted_mask,
    output logic                busy,
    output logic                done,
    output logic [2:0]          decision,
    output logic                timed_out,
    output logic                dup_err,
    output logic                bad_result
);

    state_t state;

    logic                timer_clr;
    logic                timer_en;
    logic                expire;
    logic                accept;
    logic [N_VOTERS-1:0] id_bit;
    logic [N_VOTERS-1:0] mask_next;
    logic [N_VOTERS-1:0] ballot_next;

    assign timer_clr = ((state == IDLE) || (state == DONE)) && start;
    assign timer_en  = (state == COLLECT);

    ballot_window_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .expire(expire)
    );

    // vote_valid is a one-cycle strobe with no back-pressure: a vote is taken on
    // any COLLECT cycle where it is high, and silently dropped in every other state.
    always_comb begin
        id_bit      = N_VOTERS'(1) << voter_id;
        accept      = vote_valid && !voted_mask[voter_id];
        mask_next   = voted_mask;
        ballot_next = ballot;
        if (accept) begin
            mask_next   = voted_mask | id_bit;
            ballot_next = vote_val ? (ballot | id_bit) : ballot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ballot     <= '0;
            voted_mask <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            decision   <= DEC_NONE;
            timed_out  <= 1'b0;
            dup_err    <= 1'b0;
            bad_result <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= COLLECT;
                        busy       <= 1'b1;
                        ballot     <= '0;
                        voted_mask <= '0;
                        timed_out  <= 1'b0;
                        dup_err    <= 1'b0;
                        bad_result <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (vote_valid && !accept) begin
                        dup_err <= 1'b1;
                    end
                    ballot     <= ballot_next;
                    voted_mask <= mask_next;
                    // A full mask on the expiry cycle is a normal close, not a timeout.
                    if (&mask_next) begin
                        state <= SETTLE;
                    end else if (expire) begin
                        state     <= SETTLE;
                        timed_out <= 1'b1;
                    end
                end
                SETTLE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (is_decision(result)) begin
                        decision <= result;
                    end else begin
                        decision   <= DEC_NONE;
                        bad_result <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ballot_collector.sv
// Bench for ballot_collector: a session-level reference (vote fold + timeline)
// checked every cycle, plus directed sessions pinned with literal expectations.
module tb_ballot_collector;
    import voter_pkg::*;

    localparam int T        = 16;
    localparam int PLAN_LEN = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       vote_valid;
    logic [1:0] voter_id;
    logic       vote_val;
    logic [2:0] result;
    logic [3:0] ballot;
    logic [3:0] voted_mask;
    logic       busy;
    logic       done;
    logic [2:0] decision;
    logic       timed_out;
    logic       dup_err;
    logic       bad_result;

    always #5 clk = ~clk;

    ballot_collector #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .vote_valid(vote_valid),
        .voter_id  (voter_id),
        .vote_val  (vote_val),
        .result    (result),
        .ballot    (ballot),
        .voted_mask(voted_mask),
        .busy      (busy),
        .done      (done),
        .decision  (decision),
        .timed_out (timed_out),
        .dup_err   (dup_err),
        .bad_result(bad_result)
    );

    // Majority voter on the ballot: more than half yes -> yes, exactly half -> tie.
    function automatic logic [2:0] vote_rule(input logic [3:0] b);
        int y;
        y = $countones(b);
        if (y > 2) return DEC_YES;
        if (y == 2) return DEC_TIE;
        return DEC_NO;
    endfunction

    logic corrupt_now = 1'b0;
    assign result = corrupt_now ? 3'b011 : vote_rule(ballot);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Vote plan for one session, indexed by COLLECT cycle.
    bit         p_valid[PLAN_LEN];
    logic [1:0] p_id[PLAN_LEN];
    bit         p_val[PLAN_LEN];

    // Staged model for the next session and the model of the running session.
    int         st_c_end,  s_c_end;
    bit         st_timed,  s_timed;
    logic [2:0] st_dec,    s_dec;
    bit         st_corrupt, s_corrupt;
    logic [3:0] st_mask[PLAN_LEN],   s_mask[PLAN_LEN];
    logic [3:0] st_ballot[PLAN_LEN], s_ballot[PLAN_LEN];
    bit         st_dup[PLAN_LEN],    s_dup[PLAN_LEN];

    bit         start_pending = 1'b0;
    bit         sess_active   = 1'b0;
    logic [2:0] shown_dec     = DEC_NONE;
    int         n             = 0;
    int         done_n        = -1;

    task automatic build_model(input bit corrupt);
        logic [3:0] m = 4'b0;
        logic [3:0] b = 4'b0;
        bit         d = 1'b0;
        int         ce = T - 1;
        for (int k = 0; k < T; k++) begin
            if (p_valid[k]) begin
                if (m[p_id[k]]) d = 1'b1;
                else begin
                    m[p_id[k]] = 1'b1;
                    b[p_id[k]] = p_val[k];
                end
            end
            st_mask[k]   = m;
            st_ballot[k] = b;
            st_dup[k]    = d;
            if (m == 4'hF) begin
                ce = k;
                break;
            end
        end
        st_c_end   = ce;
        st_timed   = (m != 4'hF);
        st_dec     = corrupt ? DEC_NONE : vote_rule(b);
        st_corrupt = corrupt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (start_pending) begin
            if (sess_active) shown_dec = s_dec;
            s_c_end     = st_c_end;
            s_timed     = st_timed;
            s_dec       = st_dec;
            s_corrupt   = st_corrupt;
            s_mask      = st_mask;
            s_ballot    = st_ballot;
            s_dup       = st_dup;
            sess_active = 1'b1;
            start_pending = 1'b0;
            done_n      = -1;
            n           = 1;
        end else begin
            n++;
        end
        #1;
        corrupt_now = sess_active && s_corrupt && (n == s_c_end + 3);
    endtask

    // Per-cycle compare against the session timeline.
    logic [3:0] e_mask, e_ballot;
    logic [2:0] e_dec;
    bit         e_dup, e_busy, e_done, e_to, e_bad;
    int         idx;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!sess_active) begin
                e_mask = 4'b0; e_ballot = 4'b0; e_dup = 1'b0; e_busy = 1'b0;
                e_done = 1'b0; e_dec = shown_dec; e_to = 1'b0; e_bad = 1'b0;
            end else begin
                if (n < 2) begin
                    e_mask = 4'b0; e_ballot = 4'b0; e_dup = 1'b0;
                end else begin
                    idx      = (n - 2 < s_c_end) ? n - 2 : s_c_end;
                    e_mask   = s_mask[idx];
                    e_ballot = s_ballot[idx];
                    e_dup    = s_dup[idx];
                end
                e_busy = (n <= s_c_end + 3);
                e_done = (n == s_c_end + 4);
                e_dec  = (n >= s_c_end + 4) ? s_dec : shown_dec;
                e_to   = s_timed && (n >= s_c_end + 2);
                e_bad  = s_corrupt && (n >= s_c_end + 4);
                if (done === 1'b1) done_n = n;
            end
            chk("ballot",     32'(ballot),     32'(e_ballot));
            chk("voted_mask", 32'(voted_mask), 32'(e_mask));
            chk("busy",       32'(busy),       32'(e_busy));
            chk("done",       32'(done),       32'(e_done));
            chk("decision",   32'(decision),   32'(e_dec));
            chk("timed_out",  32'(timed_out),  32'(e_to));
            chk("dup_err",    32'(dup_err),    32'(e_dup));
            chk("bad_result", 32'(bad_result), 32'(e_bad));
        end
    end

    task automatic drive_garbage();
        vote_valid = 1'($urandom_range(0, 1));
        voter_id   = 2'($urandom_range(0, 3));
        vote_val   = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_plan();
        for (int k = 0; k < PLAN_LEN; k++) begin
            p_valid[k] = 1'b0;
            p_id[k]    = 2'd0;
            p_val[k]   = 1'b0;
        end
    endtask

    task automatic set_vote(input int k, input logic [1:0] id, input bit val);
        p_valid[k] = 1'b1;
        p_id[k]    = id;
        p_val[k]   = val;
    endtask

    task automatic rand_plan();
        int density;
        density = $urandom_range(10, 100);
        for (int k = 0; k < PLAN_LEN; k++) begin
            p_valid[k] = ($urandom_range(1, 100) <= density);
            p_id[k]    = 2'($urandom_range(0, 3));
            p_val[k]   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_session(input bit corrupt);
        int k;
        build_model(corrupt);
        start = 1'b1;
        drive_garbage();
        start_pending = 1'b1;
        tick();
        while (n <= s_c_end + 5) begin
            k = n - 1;
            if (k < PLAN_LEN) begin
                vote_valid = p_valid[k];
                voter_id   = p_id[k];
                vote_val   = p_val[k];
            end else begin
                drive_garbage();
            end
            start = (k <= s_c_end) ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
        end
        start      = 1'b0;
        vote_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int c);
        for (int i = 0; i < c; i++) begin
            drive_garbage();
            tick();
        end
        vote_valid = 1'b0;
    endtask

    task automatic plan_four(input bit v0, input bit v1, input bit v2, input bit v3);
        clear_plan();
        set_vote(0, 2'd0, v0);
        set_vote(1, 2'd1, v1);
        set_vote(2, 2'd2, v2);
        set_vote(3, 2'd3, v3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ballot"},   32'(ballot),     32'h0);
        chk({tag, "_mask"},     32'(voted_mask), 32'h0);
        chk({tag, "_busy"},     32'(busy),       32'h0);
        chk({tag, "_done"},     32'(done),       32'h0);
        chk({tag, "_decision"}, 32'(decision),   32'h0);
        chk({tag, "_flags"},    32'({timed_out, dup_err, bad_result}), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        vote_valid = 1'b0;
        voter_id   = 2'd0;
        vote_val   = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle_cycles(3);

        // Three yes, one no: yes, done two cycles after the last vote.
        plan_four(1'b1, 1'b1, 1'b1, 1'b0);
        run_session(1'b0);
        chk("t1_ballot",   32'(ballot),   32'h7);
        chk("t1_decision", 32'(decision), 32'(3'b100));
        chk("t1_done_n",   32'(done_n),   32'd7);
        chk("t1_flags",    32'({timed_out, dup_err, bad_result}), 32'h0);

        plan_four(1'b1, 1'b0, 1'b1, 1'b0);
        run_session(1'b0);
        chk("t2_ballot",   32'(ballot),   32'h5);
        chk("t2_decision", 32'(decision), 32'(3'b010));

        plan_four(1'b0, 1'b0, 1'b1, 1'b0);
        run_session(1'b0);
        chk("t2b_decision", 32'(decision), 32'(3'b001));

        // Lone yes from voter 2: window runs out at timer 15.
        clear_plan();
        set_vote(5, 2'd2, 1'b1);
        run_session(1'b0);
        chk("t3_timed_out", 32'(timed_out), 32'h1);
        chk("t3_ballot",    32'(ballot),    32'h4);
        chk("t3_decision",  32'(decision),  32'(3'b001));
        chk("t3_done_n",    32'(done_n),    32'd19);

        // Repeat vote from voter 1: first vote wins.
        clear_plan();
        set_vote(0, 2'd1, 1'b1);
        set_vote(1, 2'd1, 1'b0);
        set_vote(2, 2'd0, 1'b0);
        set_vote(3, 2'd2, 1'b0);
        set_vote(4, 2'd3, 1'b1);
        run_session(1'b0);
        chk("t4_dup_err",  32'(dup_err),  32'h1);
        chk("t4_ballot",   32'(ballot),   32'ha);
        chk("t4_decision", 32'(decision), 32'(3'b010));
        idle_cycles(6);

        // Voter output forced to 011 in the capture cycle.
        plan_four(1'b1, 1'b1, 1'b1, 1'b1);
        run_session(1'b1);
        chk("t5_decision", 32'(decision),   32'h0);
        chk("t5_bad",      32'(bad_result), 32'h1);
        chk("t5_done_n",   32'(done_n),     32'd7);

        for (int s = 0; s < 40; s++) begin
            rand_plan();
            run_session($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 4));
        end

        // Reset in the middle of a session with two votes in.
        plan_four(1'b1, 1'b1, 1'b1, 1'b1);
        run_session(1'b0);
        clear_plan();
        set_vote(0, 2'd0, 1'b1);
        set_vote(1, 2'd3, 1'b1);
        build_model(1'b0);
        start = 1'b1;
        start_pending = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vote_valid = p_valid[k];
            voter_id   = p_id[k];
            vote_val   = p_val[k];
            tick();
        end
        vote_valid = 1'b0;
        chk("t6_pre_mask", 32'(voted_mask), 32'h9);
        rst_n = 1'b0;
        #1;
        sess_active   = 1'b0;
        shown_dec     = DEC_NONE;
        start_pending = 1'b0;
        corrupt_now   = 1'b0;
        check_reset_outputs("t6_rst");
        tick();
        tick();
        rst_n = 1'b1;
        idle_cycles(2);

        plan_four(1'b1, 1'b1, 1'b1, 1'b0);
        run_session(1'b0);
        chk("t6_ballot",   32'(ballot),   32'h7);
        chk("t6_decision", 32'(decision), 32'(3'b100));
        chk("t6_done_n",   32'(done_n),   32'd7);
        chk("t6_flags",    32'({timed_out, dup_err, bad_result}), 32'h0);
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
